// File: rtl/ysyx_22050499_pkg.sv
// Shared constants and result type for the RV32E write-back path (EXU, LSU, WBU).
package ysyx_22050499_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NREG       = 16;
  localparam int REG_ADDR_W = $clog2(NREG);

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [NREG-1:0]       reg_mask_t;

  typedef struct packed {
    logic                  wen;
    reg_idx_t              rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  function automatic reg_mask_t reg_onehot(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22050499_wbu_if.sv
// Valid/ready result channel from an execution unit into the write-back unit.
interface ysyx_22050499_wbu_if;

  logic                        valid;
  logic                        ready;
  ysyx_22050499_pkg::wb_req_t  req;

  modport master (output valid, output req, input ready);
  modport slave  (input valid, input req, output ready);

endinterface

// File: rtl/ysyx_22050499_wb_arb.sv
// Two-way round-robin arbiter; bit 0 is the EXU, bit 1 the LSU.
module ysyx_22050499_wb_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Set when the LSU is favoured; only a contested cycle moves it.
  logic prio_ls;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = prio_ls ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      prio_ls <= 1'b0;
    end else if (req == 2'b11) begin
      prio_ls <= ~prio_ls;
    end
  end

endmodule

// File: rtl/ysyx_22050499_wbu.sv
// Write-back unit: arbitrates EXU/LSU results into one GPR write port, tracks the
// per-register pending-write scoreboard and counts retired instructions.
module ysyx_22050499_wbu
  import ysyx_22050499_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic                  iss_wen,
  input  reg_idx_t              iss_rd,
  output logic                  iss_ready,
  input  reg_idx_t              rs1,
  input  reg_idx_t              rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  ysyx_22050499_wbu_if.slave    ex,
  ysyx_22050499_wbu_if.slave    ls,
  output logic                  gpr_wen,
  output reg_idx_t              gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic                  commit,
  output logic [63:0]           instret,
  output logic                  wb_err
);

  logic [1:0] gnt;
  wb_req_t    win;

  ysyx_22050499_wb_arb u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({ls.valid, ex.valid}),
    .gnt   (gnt)
  );

  // The write stage never stalls, so a grant is an acceptance.
  assign ex.ready = gnt[0];
  assign ls.ready = gnt[1];
  assign win      = gnt[1] ? ls.req : ex.req;

  reg_mask_t             busy;
  reg_mask_t             set_mask;
  reg_mask_t             clr_mask;
  logic                  wb_v;
  logic                  wb_wen;
  reg_idx_t              wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  assign iss_ready = !(iss_wen && busy[iss_rd]);
  assign rs1_busy  = busy[rs1];
  assign rs2_busy  = busy[rs2];

  assign gpr_wen   = wb_v && wb_wen && (wb_rd != '0);
  assign gpr_waddr = wb_rd;
  assign gpr_wdata = wb_data;
  assign commit    = wb_v;

  // x0 is never marked, so busy[0] stays 0 without a dedicated mask.
  assign set_mask = (iss_valid && iss_ready && iss_wen && (iss_rd != '0)) ? reg_onehot(iss_rd) : '0;
  assign clr_mask = gpr_wen ? reg_onehot(wb_rd) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: busy is a flop vector rather than a RAM, so reset clears every pending bit at once.
      busy    <= '0;
      wb_v    <= 1'b0;
      wb_wen  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      instret <= '0;
      wb_err  <= 1'b0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      wb_v <= |gnt;
      // Address and data only move on a real result so the port holds its last value.
      if (|gnt) begin
        wb_wen  <= win.wen;
        wb_rd   <= win.rd;
        wb_data <= win.data;
      end
      if (wb_v) begin
        instret <= instret + 64'd1;
      end
      if (gpr_wen && !busy[wb_rd]) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ysyx_22050499_wbu.md
# ysyx_22050499_wbu

Write-back unit for the RV32E core: accepts completed results from the execute unit (EXU) and load/store unit (LSU), arbitrates between them, and drives the single write port of the 16-entry general-purpose register file one cycle later. Also owns the register scoreboard (per-register pending-write bits) used by decode for RAW/WAW stalls, and the 64-bit retired-instruction counter.

## Interface
- `DATA_WIDTH`, 32: result / register width
- `NREG`, 16: architectural registers (x0 hard-wired zero)
- `REG_ADDR_W`, 4: register index width, log2(NREG)

- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `iss_valid` in 1: decode issuing an instruction
- `iss_wen` in 1: issued instruction writes `iss_rd`
- `iss_rd` in REG_ADDR_W: destination of issued instruction
- `iss_ready` out 1: issue may proceed (WAW-free)
- `rs1`, `rs2` in REG_ADDR_W: decode source indices
- `rs1_busy`, `rs2_busy` out 1: source has pending write (RAW stall)
- `ex_valid`, `ex_wen` in 1; `ex_rd` in REG_ADDR_W; `ex_data` in DATA_WIDTH: EXU result
- `ex_ready` out 1: EXU result accepted this cycle
- `ls_valid`, `ls_wen` in 1; `ls_rd` in REG_ADDR_W; `ls_data` in DATA_WIDTH: LSU result
- `ls_ready` out 1: LSU result accepted this cycle
- `gpr_wen` out 1; `gpr_waddr` out REG_ADDR_W; `gpr_wdata` out DATA_WIDTH: register-file write port
- `commit` out 1: one instruction retired this cycle
- `instret` out 64: retired-instruction count
- `wb_err` out 1: sticky, write to a register with no pending bit

## Operation
- Scoreboard `busy[NREG-1:0]`. Bit set on issue handshake (`iss_valid & iss_ready & iss_wen & iss_rd!=0`); cleared when the write stage commits that register. `busy[0]` is always 0.
- `iss_ready = !(iss_wen & busy[iss_rd])`: combinational from registered `busy`. At most one in-flight write per register, so results may arrive out of order between EXU and LSU.
- `rsN_busy = busy[rsN]` (0 for index 0). No forwarding.
- Arbitration, two requesters, one grant per cycle:
  - If only one is valid, it wins.
  - If both are valid, round-robin: the requester not granted last time wins.
  - The pointer updates only on a both-valid cycle.
  - Losing requester sees `ready=0` and must hold.
- Write stage is one register: `{v, wen, rd, data}` loaded every cycle from the winner (`v=0` if none). It never stalls, so the winner's ready is unconditional.
- Write stage outputs:
  - `gpr_wen = v & wen & rd!=0`; `gpr_waddr = rd`; `gpr_wdata = data`.
  - `gpr_waddr`/`gpr_wdata` hold their last values when `v=0`.
  - `commit = v`, including non-writing instructions and rd=0.
  - `instret` increments by 1 on each `commit` cycle and wraps at 2^64.
- `wb_err` is set when `gpr_wen` is asserted with `busy[rd]=0`. The write still happens. Cleared only by reset.

## Timing
- Result handshake in cycle N. In cycle N+1: `gpr_wen`, `commit`, and the data are visible. At the end of N+1, the GPR write, `busy` clear and `instret` increment all take effect on the same edge.
- Decode sees `rsN_busy=0` from cycle N+2; register-file read of that index returns the new value in N+2.
- Issue and commit of the same rd in the same cycle: `busy` is still 1 at issue, so `iss_ready=0` (conservative stall); issue succeeds next cycle.
- Set and clear of different registers in the same cycle: both apply.
- Throughput: one result per cycle sustained.
- Reset (asserted anytime, including mid-transfer) takes effect immediately and drops any in-flight write:
  - `gpr_wen`, `commit`, `wb_err` = 0
  - `gpr_waddr`, `gpr_wdata` = 0
  - `busy` = 0
  - `instret` = 0
  - write stage `v` = 0
  - round-robin pointer = EXU favoured

## Structure
- Shared package `ysyx_22050499_pkg`:
  - constants `DATA_WIDTH`, `NREG`, `REG_ADDR_W`
  - typedef `wb_req_t {wen, rd, data}` used by EXU, LSU and WBU
- Sub-module `ysyx_22050499_wb_arb`: 2-way round-robin arbiter (valid in, grant out, pointer flop).
- Scoreboard, write stage and counter live in the top.

## Test plan
- Reset, then issue rd=5 and send EXU result `rd=5 data=0xDEADBEEF`: `gpr_wen=1 gpr_waddr=5 gpr_wdata=0xDEADBEEF` one cycle after the handshake; `rs1_busy` for x5 drops two cycles after the handshake; `instret=1`.
- EXU and LSU valid together for 4 cycles: grants alternate starting with EXU (E, L, E, L); losing ready=0; 4 commits, `instret=4`.
- Issue rd=3, then try to issue rd=3 again: `iss_ready=0` until the rd=3 commit edge, 1 the cycle after; `wb_err` stays 0.
- LSU result `wen=1 rd=0 data=0x1234`: `gpr_wen=0`, `commit=1`, `busy` unchanged.
- EXU result `rd=7` with no prior issue of x7: write occurs and `wb_err=1`, remaining set through later traffic until reset.
- Assert reset while the write stage holds a valid write to x9: `gpr_wen` drops immediately, `busy[9]=0`, `instret=0`, and no write to x9 after reset is released.
